// File: rtl/spi_host_pkg.sv
// Shared types and constants for the SPI mode-0 host master.
// Holds the FSM state encoding, the pin idle/active levels and a divider-width helper.
package spi_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

   localparam logic SCK_IDLE  = 1'b0;
   localparam logic SS_ACTIVE = 1'b0;

   // Counter width able to hold 0..clk_div-1; never narrower than one bit.
   function automatic int div_width(input int clk_div);
      return (clk_div < 2) ? 1 : $clog2(clk_div);
   endfunction

endpackage

// File: rtl/spi_host_tick.sv
// Divider counter for the SPI host: counts 0..CLK_DIV-1 and flags the terminal count.
// Restart forces the count back to zero so every timed state starts a fresh period.
module spi_host_tick
   import spi_host_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = div_width(CLK_DIV);
   localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || restart || cnt_reg == TERM) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   assign tick = (cnt_reg == TERM);

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 master: turns a valid/ready word stream into framed SPI transfers.
// ss_n stays low across words until a word tagged tx_last completes; each received word pulses rx_valid.
module spi_host_master
   import spi_host_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_last,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              sck,
   output logic              ss_n,
   output logic              mosi,
   input  logic              miso
);

   localparam int BW = (DATA_W < 2) ? 1 : $clog2(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   spi_state_t        state_reg;
   logic [DATA_W-1:0] tx_shift_reg;
   logic [DATA_W-1:0] tx_shift_next;
   logic [DATA_W-1:0] rx_shift_reg;
   logic [DATA_W-1:0] rx_data_reg;
   logic [BW-1:0]     bit_cnt_reg;
   logic              last_reg;
   logic              sck_reg;
   logic              ss_n_reg;
   logic              mosi_reg;
   logic              tx_ready_reg;
   logic              rx_valid_reg;
   logic              busy_reg;
   logic              tick;
   logic              restart;
   logic              handshake;

   // The divider is held at zero while waiting for data so SETUP always gets a full half-period.
   assign restart       = (state_reg == ST_IDLE) || (state_reg == ST_WAIT);
   assign handshake     = tx_valid & tx_ready_reg;
   assign tx_shift_next = tx_shift_reg << 1;

   spi_host_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         tx_shift_reg <= '0;
         rx_shift_reg <= '0;
         rx_data_reg  <= '0;
         bit_cnt_reg  <= '0;
         last_reg     <= 1'b0;
         sck_reg      <= SCK_IDLE;
         ss_n_reg     <= ~SS_ACTIVE;
         mosi_reg     <= 1'b0;
         tx_ready_reg <= 1'b0;
         rx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         rx_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_WAIT: begin
               if (handshake) begin
                  tx_shift_reg <= tx_data;
                  last_reg     <= tx_last;
                  mosi_reg     <= tx_data[DATA_W-1];
                  bit_cnt_reg  <= '0;
                  ss_n_reg     <= SS_ACTIVE;
                  tx_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= ST_SETUP;
               end else begin
                  tx_ready_reg <= 1'b1;
               end
            end
            ST_SETUP, ST_LOW: begin
               if (tick) begin
                  sck_reg      <= ~SCK_IDLE;
                  rx_shift_reg <= (rx_shift_reg << 1) | DATA_W'(miso);
                  state_reg    <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (tick) begin
                  sck_reg <= SCK_IDLE;
                  if (bit_cnt_reg == LAST_BIT) begin
                     rx_valid_reg <= 1'b1;
                     rx_data_reg  <= rx_shift_reg;
                     if (last_reg) begin
                        state_reg <= ST_HOLD;
                     end else begin
                        tx_ready_reg <= 1'b1;
                        state_reg    <= ST_WAIT;
                     end
                  end else begin
                     bit_cnt_reg  <= bit_cnt_reg + BW'(1);
                     tx_shift_reg <= tx_shift_next;
                     mosi_reg     <= tx_shift_next[DATA_W-1];
                     state_reg    <= ST_LOW;
                  end
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  ss_n_reg  <= ~SS_ACTIVE;
                  state_reg <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (tick) begin
                  tx_ready_reg <= 1'b1;
                  busy_reg     <= 1'b0;
                  state_reg    <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_ready = tx_ready_reg;
   assign rx_valid = rx_valid_reg;
   assign rx_data  = rx_data_reg;
   assign busy     = busy_reg;
   assign sck      = sck_reg;
   assign ss_n     = ss_n_reg;
   assign mosi     = mosi_reg;

endmodule

// File: tb/tb_spi_host_master.sv
// Self-checking bench for spi_host_master: CLK_DIV=2 and CLK_DIV=1 instances.
// A behavioural slave shifts its reply out on sck falls; expectations come from the edge-timing formulas.
`timescale 1ns/1ps
module tb_spi_host_master;

   localparam int W  = 8;
   localparam int DA = 2;
   localparam int DB = 1;
   localparam int RX_OFF_A  = 1 + 2 * W * DA;
   localparam int SS_OFF_A  = 1 + (2 * W + 1) * DA;
   localparam int RDY_OFF_A = 1 + (2 * W + 2) * DA;
   localparam int RX_OFF_B  = 1 + 2 * W * DB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   logic         rst_a, tx_valid_a, tx_ready_a, tx_last_a, rx_valid_a, busy_a, sck_a, ss_n_a, mosi_a, miso_a;
   logic [W-1:0] tx_data_a, rx_data_a;
   logic         rst_b, tx_valid_b, tx_ready_b, tx_last_b, rx_valid_b, busy_b, sck_b, ss_n_b, mosi_b, miso_b;
   logic [W-1:0] tx_data_b, rx_data_b;

   spi_host_master #(.CLK_DIV(DA), .DATA_W(W)) dut_a (
      .clk(clk), .rst(rst_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
      .tx_last(tx_last_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a), .busy(busy_a),
      .sck(sck_a), .ss_n(ss_n_a), .mosi(mosi_a), .miso(miso_a));

   spi_host_master #(.CLK_DIV(DB), .DATA_W(W)) dut_b (
      .clk(clk), .rst(rst_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
      .tx_last(tx_last_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b), .busy(busy_b),
      .sck(sck_b), .ss_n(ss_n_b), .mosi(mosi_b), .miso(miso_b));

   // Slave model for instance A: reply word loaded at handshake, next bit presented after each sck fall.
   logic [W-1:0] slave_cur_a = '0;
   int           bidx_a = 0;
   always @(negedge sck_a) begin
      if (ss_n_a === 1'b0) begin
         bidx_a++;
         if (bidx_a < W) miso_a = slave_cur_a[W-1-bidx_a];
      end
   end

   logic     mosi_bits_a[$];
   logic     mosi_bits_b[$];
   int       rise_cnt_a = 0;
   int       rise_cnt_b = 0;
   logic [W-1:0] rx_got_a[$];
   int       rx_cyc_a[$];
   logic     frame_a = 1'b0;
   int       ss_gl_a = 0;
   int       sck_wait_a = 0;

   always @(posedge sck_a) begin rise_cnt_a++; mosi_bits_a.push_back(mosi_a); end
   always @(posedge sck_b) begin rise_cnt_b++; mosi_bits_b.push_back(mosi_b); end

   always @(negedge clk) begin
      if (rx_valid_a === 1'b1) begin
         rx_got_a.push_back(rx_data_a);
         rx_cyc_a.push_back(cyc);
      end
      if (frame_a) begin
         if (ss_n_a !== 1'b0) ss_gl_a++;
         if (tx_ready_a === 1'b1 && sck_a !== 1'b0) sck_wait_a++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no event within the cycle budget, required one", name);
   endtask

   function automatic logic [W-1:0] pack_word(input logic q[$], input int idx);
      logic [W-1:0] w = 'x;
      for (int i = 0; i < W; i++)
         if (idx * W + i < q.size()) w[W-1-i] = q[idx * W + i];
      return w;
   endfunction

   function automatic logic [W-1:0] rx_at(input int i);
      return (i < rx_got_a.size()) ? rx_got_a[i] : 'x;
   endfunction

   function automatic int rxc_at(input int i);
      return (i < rx_cyc_a.size()) ? rx_cyc_a[i] : -1000;
   endfunction

   // Offer one word to A (call at a negedge); returns the handshake cycle, exits one cycle later.
   task automatic send_a(input logic [W-1:0] d, input logic l, input logic [W-1:0] sl, output int t0);
      int k = 0;
      tx_valid_a = 1'b1; tx_data_a = d; tx_last_a = l;
      while (tx_ready_a !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      t0 = cyc;
      if (k >= 200) timeout_fail("handshake_a");
      else begin slave_cur_a = sl; bidx_a = 0; miso_a = sl[W-1]; end
      @(negedge clk);
      tx_valid_a = 1'b0; tx_data_a = W'($urandom); tx_last_a = 1'($urandom);
   endtask

   task automatic wait_idle_a();
      int k = 0;
      while (!(tx_ready_a === 1'b1 && ss_n_a === 1'b1 && busy_a === 1'b0) && k < 200) begin
         @(negedge clk); k++;
      end
      if (k >= 200) timeout_fail("idle_a");
   endtask

   task automatic clear_a();
      mosi_bits_a.delete(); rx_got_a.delete(); rx_cyc_a.delete();
      rise_cnt_a = 0; ss_gl_a = 0; sck_wait_a = 0;
   endtask

   typedef struct {
      logic [W-1:0] tx;
      logic [W-1:0] slave;
      logic [W-1:0] exp_rx;
      logic [W-1:0] exp_mosi;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int t0, t0b, k, bad, ss_rise, rdy, nw, rxc, seq_bad;
      logic [W-1:0] exp_tx_q[$];
      logic [W-1:0] exp_rx_q[$];
      int           t0_q[$];
      logic [W-1:0] d, sl;

      vecs[0] = '{tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'hA5};
      vecs[1] = '{tx: 8'h00, slave: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00};
      vecs[2] = '{tx: 8'hFF, slave: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF};
      vecs[3] = '{tx: 8'h81, slave: 8'h7E, exp_rx: 8'h7E, exp_mosi: 8'h81};

      rst_a = 1'b1; tx_valid_a = 1'b0; tx_data_a = '0; tx_last_a = 1'b0; miso_a = 1'b0;
      rst_b = 1'b1; tx_valid_b = 1'b0; tx_data_b = '0; tx_last_b = 1'b0; miso_b = 1'b1;
      repeat (3) @(negedge clk);

      check("reset_sck", 32'(sck_a), 0);
      check("reset_ss_n", 32'(ss_n_a), 1);
      check("reset_mosi", 32'(mosi_a), 0);
      check("reset_tx_ready", 32'(tx_ready_a), 0);
      check("reset_rx_valid", 32'(rx_valid_a), 0);
      check("reset_rx_data", 32'(rx_data_a), 0);
      check("reset_busy", 32'(busy_a), 0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(tx_ready_a), 1);

      // Single-word frames from the vector table.
      foreach (vecs[v]) begin
         clear_a();
         send_a(vecs[v].tx, 1'b1, vecs[v].slave, t0);
         ss_rise = -1; rdy = -1;
         for (int i = 0; i < 80 && rdy < 0; i++) begin
            @(negedge clk);
            if (ss_n_a === 1'b1 && ss_rise < 0) ss_rise = cyc;
            if (tx_ready_a === 1'b1 && rdy < 0) rdy = cyc;
         end
         $display("single tx=%02h slave=%02h rx=%02h rx_at=T0+%0d ss_up=T0+%0d ready=T0+%0d",
                  vecs[v].tx, vecs[v].slave, rx_at(0), rxc_at(0) - t0, ss_rise - t0, rdy - t0);
         check("single_rises", rise_cnt_a, W);
         check("single_mosi", 32'(pack_word(mosi_bits_a, 0)), 32'(vecs[v].exp_mosi));
         check("single_rx_count", rx_got_a.size(), 1);
         check("single_rx_data", 32'(rx_at(0)), 32'(vecs[v].exp_rx));
         check("single_rx_cycle", rxc_at(0) - t0, RX_OFF_A);
         check("single_ss_rise", ss_rise - t0, SS_OFF_A);
         check("single_ready", rdy - t0, RDY_OFF_A);
         check("single_rx_hold", 32'(rx_data_a), 32'(vecs[v].exp_rx));
      end

      // Two-word frame with a 5-cycle stall in WAIT.
      clear_a();
      send_a(8'h01, 1'b0, 8'h5A, t0);
      frame_a = 1'b1;
      k = 0;
      while (tx_ready_a !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) timeout_fail("two_word_wait");
      repeat (5) @(negedge clk);
      send_a(8'hFF, 1'b1, 8'hC3, t0b);
      k = 0;
      while (rx_got_a.size() < 2 && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) timeout_fail("two_word_rx");
      frame_a = 1'b0;
      wait_idle_a();
      $display("two-word rx0=%02h rx1=%02h rises=%0d ss_glitch=%0d sck_in_wait=%0d",
               rx_at(0), rx_at(1), rise_cnt_a, ss_gl_a, sck_wait_a);
      check("two_ss_low", ss_gl_a, 0);
      check("two_sck_wait", sck_wait_a, 0);
      check("two_rises", rise_cnt_a, 2 * W);
      check("two_rx_count", rx_got_a.size(), 2);
      check("two_rx0", 32'(rx_at(0)), 32'h5A);
      check("two_rx1", 32'(rx_at(1)), 32'hC3);
      check("two_mosi0", 32'(pack_word(mosi_bits_a, 0)), 32'h01);
      check("two_mosi1", 32'(pack_word(mosi_bits_a, 1)), 32'hFF);
      check("two_rx1_cycle", rxc_at(1) - t0b, RX_OFF_A);

      // Reset one cycle after the third sck rise.
      clear_a();
      send_a(8'hC7, 1'b1, 8'h99, t0);
      k = 0;
      while (rise_cnt_a < 3 && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) timeout_fail("reset_mid_rise");
      rst_a = 1'b1;
      @(negedge clk);
      $display("reset-mid ss_n=%0b sck=%0b tx_ready=%0b busy=%0b", ss_n_a, sck_a, tx_ready_a, busy_a);
      check("mid_ss_n", 32'(ss_n_a), 1);
      check("mid_sck", 32'(sck_a), 0);
      check("mid_mosi", 32'(mosi_a), 0);
      check("mid_busy", 32'(busy_a), 0);
      check("mid_tx_ready", 32'(tx_ready_a), 0);
      check("mid_rx_data", 32'(rx_data_a), 0);
      rst_a = 1'b0;
      @(negedge clk);
      check("mid_ready_after", 32'(tx_ready_a), 1);
      repeat (40) @(negedge clk);
      check("mid_no_rx", rx_got_a.size(), 0);
      check("mid_rises", rise_cnt_a, 3);

      // Idle for 100 cycles, then tx_valid under reset.
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (ss_n_a !== 1'b1 || sck_a !== 1'b0 || busy_a !== 1'b0 || rx_valid_a !== 1'b0 || tx_ready_a !== 1'b1) bad++;
      end
      $display("idle 100 cycles: bad cycles=%0d", bad);
      check("idle_quiet", bad, 0);
      rst_a = 1'b1; tx_valid_a = 1'b1; tx_data_a = 8'h55; tx_last_a = 1'b1;
      @(negedge clk);
      check("rst_valid_ready", 32'(tx_ready_a), 0);
      repeat (3) @(negedge clk);
      check("rst_valid_ss_n", 32'(ss_n_a), 1);
      check("rst_valid_busy", 32'(busy_a), 0);
      tx_valid_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      check("rst_valid_ready_after", 32'(tx_ready_a), 1);
      check("rst_valid_no_rx", rx_got_a.size(), 0);

      // Randomised frames of 1..3 words against the word-level model.
      for (int f = 0; f < 20; f++) begin
         clear_a();
         exp_tx_q.delete(); exp_rx_q.delete(); t0_q.delete();
         nw = $urandom_range(1, 3);
         for (int w = 0; w < nw; w++) begin
            d = W'($urandom); sl = W'($urandom);
            send_a(d, (w == nw - 1), sl, t0);
            if (w == 0) frame_a = 1'b1;
            exp_tx_q.push_back(d); exp_rx_q.push_back(sl); t0_q.push_back(t0);
            if (w != nw - 1) repeat ($urandom_range(0, 6)) @(negedge clk);
         end
         k = 0;
         while (rx_got_a.size() < nw && k < 200) begin @(negedge clk); k++; end
         if (k >= 200) timeout_fail("rand_rx");
         frame_a = 1'b0;
         wait_idle_a();
         $display("rand frame %0d words=%0d rx_count=%0d rises=%0d", f, nw, rx_got_a.size(), rise_cnt_a);
         check("rand_rx_count", rx_got_a.size(), nw);
         check("rand_rises", rise_cnt_a, nw * W);
         check("rand_ss_low", ss_gl_a, 0);
         for (int w = 0; w < nw; w++) begin
            check("rand_rx_data", 32'(rx_at(w)), 32'(exp_rx_q[w]));
            check("rand_mosi", 32'(pack_word(mosi_bits_a, w)), 32'(exp_tx_q[w]));
            check("rand_rx_cycle", rxc_at(w) - t0_q[w], RX_OFF_A);
         end
      end

      // CLK_DIV=1 instance: sck toggles every cycle, miso tied high.
      tx_valid_b = 1'b1; tx_data_b = 8'h80; tx_last_b = 1'b1;
      k = 0;
      while (tx_ready_b !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) timeout_fail("handshake_b");
      t0 = cyc;
      @(negedge clk);
      tx_valid_b = 1'b0; tx_data_b = 8'h3F; tx_last_b = 1'b0;
      seq_bad = 0; rxc = -1000;
      for (int j = 0; j <= 2 * W; j++) begin
         if ((sck_b === 1'b1) != (j % 2 == 1)) seq_bad++;
         if (rx_valid_b === 1'b1 && rxc < 0) rxc = cyc;
         if (j < 2 * W) @(negedge clk);
      end
      $display("div1 rx=%02h rx_at=T0+%0d sck_seq_errors=%0d rises=%0d", rx_data_b, rxc - t0, seq_bad, rise_cnt_b);
      check("div1_sck_toggle", seq_bad, 0);
      check("div1_rx_cycle", rxc - t0, RX_OFF_B);
      check("div1_rx_data", 32'(rx_data_b), 32'hFF);
      check("div1_mosi", 32'(pack_word(mosi_bits_b, 0)), 32'h80);
      check("div1_rises", rise_cnt_b, W);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required finish within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
